// File: rtl/nios2system_multi_timer_if.sv
// Avalon-MM slave bus for the multi-channel interval timer.
// One word per register, registered read data, no wait states.
interface nios2system_multi_timer_if #(
   parameter int ADDR_W = 5
) ();
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/nios2system_multi_timer.sv
// NUM_CH independent prescaled down-counters with snapshot,
// one-shot/continuous modes, compare PWM and per-channel irq.
module nios2system_multi_timer #(
   parameter int          NUM_CH     = 4,
   parameter int          CNT_W      = 32,
   parameter logic [31:0] PERIOD_RST = 32'd4999,
   localparam int         ADDR_W     = $clog2(NUM_CH) + 3
) (
   input  logic                    clk,
   input  logic                    reset,
   nios2system_multi_timer_if.slave bus,
   output logic [NUM_CH-1:0]       irq,
   output logic                    irq_any,
   output logic [NUM_CH-1:0]       pwm_out
);

   localparam logic [CNT_W-1:0] PRST = CNT_W'(PERIOD_RST);

   logic [CNT_W-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH];
   logic [CNT_W-1:0] per_q [NUM_CH], per_d [NUM_CH];
   logic [CNT_W-1:0] cmp_q [NUM_CH], cmp_d [NUM_CH];
   logic [CNT_W-1:0] snp_q [NUM_CH], snp_d [NUM_CH];
   logic [15:0]      psc_q [NUM_CH], psc_d [NUM_CH];
   logic [15:0]      pre_q [NUM_CH], pre_d [NUM_CH];
   logic [NUM_CH-1:0] run_q, run_d, to_q, to_d;
   logic [NUM_CH-1:0] ito_q, ito_d, cont_q, cont_d;
   logic [NUM_CH-1:0] pwe_q, pwe_d, rl_q, rl_d;
   logic [31:0]      rd_q, rd_d;

   logic [ADDR_W-1:0] ch_a;
   logic [2:0]        reg_a;
   logic [7:0]        wreg;
   logic [CNT_W-1:0]  wval;
   logic [NUM_CH-1:0] wsel, w_sts, w_ctl, w_per, w_cmp, w_psc, w_snp;
   logic [NUM_CH-1:0] start, stop, tick, expire;

   assign ch_a  = bus.address >> 3;
   assign reg_a = bus.address[2:0];
   assign wreg  = (bus.chipselect && !bus.write_n) ? (8'd1 << reg_a) : 8'd0;
   assign wval  = bus.writedata[CNT_W-1:0];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
      assign wsel[g]   = (ch_a == ADDR_W'(g));
      assign w_sts[g]  = wsel[g] & wreg[0];
      assign w_ctl[g]  = wsel[g] & wreg[1];
      assign w_per[g]  = wsel[g] & wreg[2];
      assign w_cmp[g]  = wsel[g] & wreg[3];
      assign w_psc[g]  = wsel[g] & wreg[4];
      assign w_snp[g]  = wsel[g] & wreg[5];
      assign start[g]  = w_ctl[g] & bus.writedata[2];
      assign stop[g]   = w_ctl[g] & bus.writedata[3];
      assign tick[g]   = run_q[g] && (pre_q[g] == psc_q[g]);
      assign expire[g] = tick[g] && (cnt_q[g] == '0);
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         per_d[i]  = w_per[i] ? wval : per_q[i];
         cmp_d[i]  = w_cmp[i] ? wval : cmp_q[i];
         snp_d[i]  = w_snp[i] ? cnt_q[i] : snp_q[i];
         psc_d[i]  = w_psc[i] ? bus.writedata[15:0] : psc_q[i];
         ito_d[i]  = w_ctl[i] ? bus.writedata[0] : ito_q[i];
         cont_d[i] = w_ctl[i] ? bus.writedata[1] : cont_q[i];
         pwe_d[i]  = w_ctl[i] ? bus.writedata[4] : pwe_q[i];
         rl_d[i]   = w_per[i];
         pre_d[i]  = (!run_q[i] || start[i] || rl_q[i] || tick[i]) ?
                     16'd0 : pre_q[i] + 16'd1;
         if (rl_q[i])
            cnt_d[i] = per_q[i];
         else if (tick[i])
            cnt_d[i] = expire[i] ? per_q[i] : cnt_q[i] - CNT_W'(1);
         // clearing write beats a timeout on the same edge
         if (w_sts[i])       to_d[i] = 1'b0;
         else if (expire[i]) to_d[i] = 1'b1;
         else                to_d[i] = to_q[i];
         if (start[i])                    run_d[i] = 1'b1;
         else if (stop[i])                run_d[i] = 1'b0;
         else if (w_per[i] || rl_q[i])    run_d[i] = 1'b0;
         else if (expire[i] && !cont_q[i]) run_d[i] = 1'b0;
         else                             run_d[i] = run_q[i];
      end
   end

   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wsel[i]) begin
            case (reg_a)
               3'd0:    rd_d = {30'd0, run_q[i], to_q[i]};
               3'd1:    rd_d = {27'd0, pwe_q[i], 2'b00, cont_q[i], ito_q[i]};
               3'd2:    rd_d = 32'(per_q[i]);
               3'd3:    rd_d = 32'(cmp_q[i]);
               3'd4:    rd_d = {16'd0, psc_q[i]};
               3'd5:    rd_d = 32'(snp_q[i]);
               default: rd_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= PRST;
            per_q[i] <= PRST;
            cmp_q[i] <= '0;
            snp_q[i] <= '0;
            psc_q[i] <= '0;
            pre_q[i] <= '0;
         end
         run_q  <= '0;
         to_q   <= '0;
         ito_q  <= '0;
         cont_q <= '0;
         pwe_q  <= '0;
         rl_q   <= '0;
         rd_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            per_q[i] <= per_d[i];
            cmp_q[i] <= cmp_d[i];
            snp_q[i] <= snp_d[i];
            psc_q[i] <= psc_d[i];
            pre_q[i] <= pre_d[i];
         end
         run_q  <= run_d;
         to_q   <= to_d;
         ito_q  <= ito_d;
         cont_q <= cont_d;
         pwe_q  <= pwe_d;
         rl_q   <= rl_d;
         rd_q   <= rd_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         irq[i]     = to_q[i] & ito_q[i];
         pwm_out[i] = run_q[i] & pwe_q[i] & (cnt_q[i] < cmp_q[i]);
      end
   end

   assign irq_any      = |irq;
   assign bus.readdata = rd_q;

endmodule

// File: doc/nios2system_multi_timer.md
# nios2system_multi_timer

Parametrised multi-channel Avalon-MM interval timer for the Nios II system: the next generation of the single fixed 16-bit-bus interval timer. It provides NUM_CH independent down-counters of CNT_W bits, each with a programmable prescaler, one-shot/continuous modes, counter snapshot, and a compare-driven PWM output. Per-channel and combined interrupts go to the Nios II IRQ inputs.

## Interface
Parameters:
- NUM_CH, 4: channel count, 1–8.
- CNT_W, 32: counter, PERIOD and COMPARE width, 8–32.
- PERIOD_RST, 4999: reset value of every PERIOD register and counter.
- ADDR_W, clog2(NUM_CH)+3: derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address; [ADDR_W-1:3] selects the channel, [2:0] selects the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  NUM_CH  per-channel interrupt.
- irq_any  out  1  OR of irq.
- pwm_out  out  NUM_CH  per-channel PWM output.

## Operation
Per-channel register map (word offsets):
- 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
- 1 CONTROL: bit0 ITO, bit1 CONT, bit4 PWM_EN, all stored. bit2 START and bit3 STOP are write-only strobes that read 0.
- 2 PERIOD: CNT_W bits. A write stops the channel and forces a reload on the next edge.
- 3 COMPARE: CNT_W bits.
- 4 PRESC: 16 bits. The counter advances once every PRESC+1 clocks.
- 5 SNAP: a write latches the counter; a read returns the latched value.
- 6–7: reserved. Reads return 0; writes are ignored.
- An unused channel index, when NUM_CH is not a power of 2, reads 0 and ignores writes.
- Unused upper bits of all registers read 0.

Per-channel behaviour:
- Prescaler: a 16-bit counter counts up while RUN=1. tick=1 when the prescaler equals PRESC; the prescaler then returns to 0. The prescaler is cleared while stopped, on START, and on force-reload.
- Counter on tick with RUN=1:
  - if the counter is 0: reload from PERIOD and set TO; if CONT=0, clear RUN in the same edge.
  - otherwise: decrement by 1.
- Force-reload: on the edge after a PERIOD write, the counter is loaded from PERIOD and RUN stays 0.
- RUN priority: START > STOP > force-reload stop > one-shot expiry.
- TO priority: a STATUS write clears TO, and this wins over a same-cycle timeout.
- Outputs:
  - irq[i] = TO & ITO.
  - pwm_out[i] = RUN & PWM_EN & (counter < COMPARE).
  - COMPARE=0 gives constant 0; COMPARE>PERIOD gives constant 1 while running.
- Writes with chipselect=0 have no effect.
- A write to one channel never affects another channel.

Reset values:
- readdata=0, irq=0, irq_any=0, pwm_out=0.
- counters=PERIOD=PERIOD_RST, all other registers 0, RUN=0, TO=0, prescalers=0.

## Timing
- Read latency is 1 cycle: readdata is valid on the edge after the address is sampled (chipselect is ignored for reads). There are no wait states.
- Writes take effect on the edge where chipselect & ~write_n is sampled.
- START is written at edge E0, so RUN=1 after E0. With PRESC=0, the first decrement happens at E1.
- From load value P with PRESC=N: TO sets (P+1)·(N+1) clocks after the first counted edge.
- In continuous mode, the timeout period is exactly (P+1)·(N+1) clocks with no drift.
- irq and pwm_out are combinational from registers, so they are visible in the same cycle as the state change.
- A SNAP write at edge E captures the counter value present before E. A read of offset 5 issued on the next cycle returns it.
- Reset asserted mid-count: all state returns to reset values at the next edge, and no irq is pending.

## Test plan
- Reset, then read channel 0 PERIOD -> 4999; STATUS -> 0; irq=0, pwm_out=0.
- Ch1: PERIOD=4, PRESC=0, CONTROL=ITO|CONT|START -> TO/irq[1] first rises 5 clocks after start and recurs every 5 clocks; write STATUS -> irq[1] drops next cycle; ch0 and ch2 unaffected.
- Ch0: PERIOD=2, PRESC=3, one-shot START -> TO set after 12 clocks; RUN=0; counter reloaded to 2 and held.
- Ch2: PERIOD=9, COMPARE=3, PWM_EN|CONT|START -> pwm_out[2] high for 3 of every 10 clocks; COMPARE=0 -> pwm_out[2] constantly low.
- Simultaneous cases on the same edge: STATUS write with timeout -> TO=0; START|STOP in one write -> RUN=1; PERIOD write while running -> RUN=0, counter=new PERIOD next edge.
- SNAP write while counting from PERIOD=100 -> SNAP read matches the counter value at the write edge; reset asserted mid-count -> all outputs 0 the next cycle.
